multiplicador_nbits_seq: RTL and testbench

Parametrised sequential multiplier that replaces the fixed 6-bit multiplier in the ALU datapath. It takes two WIDTH-bit operands on a start pulse and computes the product with a radix-2 shift-add loop, one partial product per clock. It returns the product as a 2·WIDTH-bit magnitude plus a sign flag, so the existing display and ALU result path keeps its magnitude/sign format. A busy/done handshake replaces the free-running behaviour of the previous generation.

---
 rtl/multiplicador_nbits_seq.sv | 105 ++++++++++
 tb/tb_multiplicador_nbits_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_nbits_seq.sv
// Sequential radix-2 shift-add multiplier: magnitude/sign product, busy/done handshake.
// Optional macro MULT_SIGNED_EN selects two's-complement operands; otherwise unsigned and neg=0.
module multiplicador_nbits_seq #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] c,
  output logic               neg
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]   mag_a, mag_b, a_abs, b_abs;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH:0]   sum;
  logic [CW-1:0]      cnt;
  logic               last, accept;
  logic               sum_unused;

`ifdef MULT_SIGNED_EN
  logic sgn, neg_q;
  assign a_abs = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_abs = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign neg   = neg_q;
`else
  assign a_abs = A;
  assign b_abs = B;
  assign neg   = 1'b0;
`endif

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(WIDTH - 1));

  // Partial product enters at the top; the carry lands in sum[2W] and survives the shift.
  always_comb begin
    sum = {1'b0, acc} + (mag_b[0] ? {1'b0, mag_a, {WIDTH{1'b0}}} : '0);
  end
  assign sum_unused = sum[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a <= '0;
      mag_b <= '0;
      acc   <= '0;
      cnt   <= '0;
      c     <= '0;
    end else if (accept) begin
      mag_a <= a_abs;
      mag_b <= b_abs;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc   <= sum[2*WIDTH:1];
      mag_b <= mag_b >> 1;
      cnt   <= cnt + 1'b1;
      if (last) c <= sum[2*WIDTH:1];
    end
  end

`ifdef MULT_SIGNED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn   <= 1'b0;
      neg_q <= 1'b0;
    end else if (accept) begin
      sgn <= A[WIDTH-1] ^ B[WIDTH-1];
    end else if (state == RUN && last) begin
      // A zero product is never reported as negative.
      neg_q <= sgn & (|sum[2*WIDTH:1]);
    end
  end
`endif

endmodule

// File: tb/tb_multiplicador_nbits_seq.sv
// Scoreboard bench: stimulus pushes expected products/timing, a negedge monitor pops on done.
// A second WIDTH=16 instance covers width scaling.
module tb_multiplicador_nbits_seq;
  localparam int W  = 6;
  localparam int W2 = 2 * W;
  localparam int X  = 16;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]  a6 = '0, b6 = '0;
  logic          start6 = 1'b0, busy6, done6, neg6;
  logic [W2-1:0] c6;
  logic [X-1:0]  a16 = '0, b16 = '0;
  logic          start16 = 1'b0, busy16, done16, neg16;
  logic [2*X-1:0] c16;

  multiplicador_nbits_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A(a6), .B(b6), .start(start6),
    .busy(busy6), .done(done6), .c(c6), .neg(neg6));

  multiplicador_nbits_seq #(.WIDTH(X)) dut16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .start(start16),
    .busy(busy16), .done(done16), .c(c16), .neg(neg16));

  typedef struct {
    longint        e;
    logic [W2-1:0] c;
    logic          neg;
  } exp_t;
  exp_t q[$];

  int      n_pass = 0, n_total = 0;
  longint  cyc = 0;
  bit      mon_en = 1'b0;
  logic [W2-1:0] hold_c = '0;
  logic          hold_n = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference product of w-bit operands as a plain signed integer.
  function automatic longint prod(input longint a, input longint b, input int w);
    longint m = (longint'(1) << w) - 1;
    a &= m;
    b &= m;
`ifdef MULT_SIGNED_EN
    if (a[w-1]) a -= (longint'(1) << w);
    if (b[w-1]) b -= (longint'(1) << w);
`endif
    return a * b;
  endfunction

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   t;
    longint p = prod(longint'(a), longint'(b), W);
    t.e   = cyc;
    t.neg = (p < 0);
    t.c   = W2'(p < 0 ? -p : p);
    q.push_back(t);
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (q.size() == 0) begin
        chk("idle_busy", longint'(busy6), 0);
        chk("idle_done", longint'(done6), 0);
      end else begin
        chk("busy", longint'(busy6), longint'(cyc >= q[0].e && cyc < q[0].e + W));
        chk("done", longint'(done6), longint'(cyc == q[0].e + W));
        if (cyc == q[0].e + W) begin
          hold_c = q[0].c;
          hold_n = q[0].neg;
          void'(q.pop_front());
        end
      end
      chk("c", longint'(c6), longint'(hold_c));
      chk("neg", longint'(neg6), longint'(hold_n));
    end
  end

  // One operation; optionally pulses start with new operands 2 cycles into RUN.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit glitch);
    @(negedge clk);
    a6 = a; b6 = b; start6 = 1'b1;
    @(posedge clk); #1;
    push_exp(a, b);
    start6 = 1'b0;
    for (int i = 1; i <= W + 1; i++) begin
      @(posedge clk); #1;
      if (glitch && i == 2) begin
        start6 = 1'b1;
        a6 = W'($urandom);
        b6 = W'($urandom);
      end else if (glitch && i == 3) begin
        start6 = 1'b0;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_busy", longint'(busy6), 0);
    chk("rst_done", longint'(done6), 0);
    chk("rst_c", longint'(c6), 0);
    chk("rst_neg", longint'(neg6), 0);
    q.delete();
    hold_c = '0;
    hold_n = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  logic [W-1:0] da [7] = '{6'd9, 6'b101000, 6'b100000, 6'd0, 6'b111111, 6'd31, 6'b100000};
  logic [W-1:0] db [7] = '{6'b111001, 6'd5, 6'b100000, 6'b111011, 6'b111111, 6'd31, 6'd31};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("init_busy", longint'(busy6), 0);
    chk("init_done", longint'(done6), 0);
    chk("init_c", longint'(c6), 0);
    chk("init_neg", longint'(neg6), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    foreach (da[i]) do_op(da[i], db[i], 1'b0);
    do_op(6'd9, 6'b111001, 1'b1);
    pulse_reset();
    do_op(6'd13, 6'd11, 1'b0);

    // start held high: back-to-back acceptances every W+2 edges, operands changed mid-RUN
    @(negedge clk);
    a6 = 6'd21; b6 = 6'b110011; start6 = 1'b1;
    @(posedge clk); #1;
    push_exp(a6, b6);
    for (int k = 0; k < 2; k++) begin
      a6 = W'($urandom);
      b6 = W'($urandom);
      repeat (W + 2) @(posedge clk);
      #1;
      push_exp(a6, b6);
    end
    start6 = 1'b0;
    repeat (W + 2) @(posedge clk);

    // abort three cycles into RUN
    @(negedge clk);
    a6 = 6'd27; b6 = 6'd19; start6 = 1'b1;
    @(posedge clk); #1;
    push_exp(a6, b6);
    start6 = 1'b0;
    repeat (2) @(posedge clk);
    pulse_reset();
    repeat (W + 4) @(posedge clk);

    for (int n = 0; n < 150; n++) begin
      do_op(W'($urandom), W'($urandom), $urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (3) @(posedge clk);

    // width scaling: 300 * (-200)
    begin
      longint p;
      int     lat = 0;
      bit     seen = 1'b0;
      @(negedge clk);
      a16 = 16'd300; b16 = 16'hFF38; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      p = prod(300, 65336, X);
      while (!seen && lat < 40) begin
        @(negedge clk);
        lat++;
        seen = done16;
      end
      chk("w16_done_seen", longint'(seen), 1);
      chk("w16_latency", lat, X + 1);
      chk("w16_c", longint'(c16), p < 0 ? -p : p);
      chk("w16_neg", longint'(neg16), longint'(p < 0));
    end

    mon_en = 1'b0;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
